pipeline_stall_controller: RTL and testbench

- Consumer side of the forwarding/hazard unit. Takes id_stall/ex_stall from it, plus the instruction and data memory handshakes.
- Produces per-stage pipeline-register write enables and bubble-inject controls for the 5-stage MIPS32 pipeline.
- Owns the instruction-fetch handshake FSM: fetch buffer, wrong-path discard after a redirect.
- Owns a saturating stall-cycle counter.

---
 rtl/pipeline_stall_controller_pkg.sv | 18 +
 rtl/pipeline_stall_controller_fetch_buffer_fsm.sv | 96 +++++++++
 rtl/pipeline_stall_controller.sv | 108 ++++++++++
 tb/tb_pipeline_stall_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller_pkg
// Shared constants for the pipeline stall controller:
//   - if_state_t : instruction-fetch handshake FSM states
//   - NOP_INSTR  : encoding presented to IF/ID when no instruction is valid
// ---------------------------------------------------------------------------
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        I_IDLE    = 2'd0,
        I_REQ     = 2'd1,
        I_HOLD    = 2'd2,
        I_DISCARD = 2'd3
    } if_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_stall_controller_fetch_buffer_fsm.sv
// ---------------------------------------------------------------------------
// fetch_buffer_fsm
// Instruction-fetch handshake FSM plus a one-entry fetch buffer.
// Ports:
//   clock, reset_n       : clock, asynchronous active-low reset
//   imem_ack, imem_rdata : instruction memory response
//   if_id_we             : IF/ID register is loading this cycle
//   flush_taken          : redirect accepted this cycle
//   imem_req             : fetch request (held until ack)
//   if_instr, if_instr_valid : instruction offered to IF/ID
//   if_stall             : IF cannot supply an instruction this cycle
//   in_idle              : FSM is in its post-reset idle state
// ---------------------------------------------------------------------------
module fetch_buffer_fsm
    import pipeline_stall_controller_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        if_id_we,
    input  logic        flush_taken,
    output logic        imem_req,
    output logic [31:0] if_instr,
    output logic        if_instr_valid,
    output logic        if_stall,
    output logic        in_idle
);

    if_state_t   state_reg, state_next;
    logic [31:0] buf_reg, buf_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= I_IDLE;
            buf_reg   <= NOP_INSTR;
        end else begin
            state_reg <= state_next;
            buf_reg   <= buf_next;
        end
    end

    // Kept as plain decodes of the state register so that the stall
    // resolution in the top never depends on if_id_we through this block.
    assign in_idle  = (state_reg == I_IDLE);
    assign if_stall = ((state_reg == I_REQ) && !imem_ack) || (state_reg == I_DISCARD);

    always_comb begin
        state_next     = state_reg;
        buf_next       = buf_reg;
        imem_req       = 1'b0;
        if_instr       = NOP_INSTR;
        if_instr_valid = 1'b0;
        case (state_reg)
            I_IDLE: begin
                state_next = I_REQ;
            end
            I_REQ: begin
                imem_req = 1'b1;
                if (flush_taken) begin
                    // Ack in the redirect cycle is wrong-path: drop it. Without
                    // an ack the response is still in flight and must be eaten.
                    if (!imem_ack)
                        state_next = I_DISCARD;
                end else if (imem_ack) begin
                    if (if_id_we) begin
                        if_instr       = imem_rdata;
                        if_instr_valid = 1'b1;
                    end else begin
                        buf_next   = imem_rdata;
                        state_next = I_HOLD;
                    end
                end
            end
            I_HOLD: begin
                if_instr       = buf_reg;
                if_instr_valid = !flush_taken;
                if (flush_taken) begin
                    buf_next   = NOP_INSTR;
                    state_next = I_REQ;
                end else if (if_id_we) begin
                    state_next = I_REQ;
                end
            end
            I_DISCARD: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_next = I_REQ;
            end
            default: begin
                state_next = I_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
// Turns hazard-unit stalls and memory handshakes into per-stage write
// enables / bubble controls for a 5-stage MIPS32 pipeline, owns the fetch
// FSM and counts stalled cycles.
// Ports:
//   clock, reset_n                 : clock, asynchronous active-low reset
//   id_stall, ex_stall, if_flush   : from hazard / branch logic
//   imem_req/ack/rdata, if_instr, if_instr_valid : fetch side
//   me_mem_read/write, dmem_req/ack: data memory side
//   pc_we .. me_wb_we              : pipeline register write enables
//   if_id_bubble .. me_wb_bubble   : load NOP/zero-control when written
//   clear_counters, stall_cycles   : saturating stall counter (CNT_W bits)
// ---------------------------------------------------------------------------
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_stall,
    input  logic             ex_stall,
    input  logic             if_flush,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_instr,
    output logic             if_instr_valid,
    input  logic             me_mem_read,
    input  logic             me_mem_write,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_me_we,
    output logic             me_wb_we,
    output logic             if_id_bubble,
    output logic             id_ex_bubble,
    output logic             ex_me_bubble,
    output logic             me_wb_bubble,
    input  logic             clear_counters,
    output logic [CNT_W-1:0] stall_cycles
);

    logic me_stall;
    logic if_stall;
    logic in_idle;
    logic upstream_hold;
    logic flush_taken;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

    assign dmem_req = me_mem_read | me_mem_write;
    assign me_stall = dmem_req & ~dmem_ack;

    // Any stall at ID or later freezes PC and IF/ID.
    assign upstream_hold = me_stall | ex_stall | id_stall;

    // A redirect during a later-stage stall is ignored; ID raises it again
    // once the branch operands are available.
    assign flush_taken = if_flush & ~upstream_hold;

    // Priority: the oldest stalled stage freezes everything behind it and
    // feeds a bubble into the register just after it.
    assign me_wb_we     = 1'b1;
    assign ex_me_we     = ~me_stall;
    assign id_ex_we     = ~(me_stall | ex_stall);
    assign if_id_we     = ~upstream_hold;
    assign me_wb_bubble = me_stall;
    assign ex_me_bubble = ~me_stall & ex_stall;
    assign id_ex_bubble = ~me_stall & ~ex_stall & id_stall;
    assign if_id_bubble = ~upstream_hold & (if_stall | in_idle | flush_taken);
    // A redirect loads the PC even while IF is waiting on memory.
    assign pc_we        = ~in_idle & (flush_taken | (~upstream_hold & ~if_stall));

    fetch_buffer_fsm u_fetch (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_id_we       (if_id_we),
        .flush_taken    (flush_taken),
        .imem_req       (imem_req),
        .if_instr       (if_instr),
        .if_instr_valid (if_instr_valid),
        .if_stall       (if_stall),
        .in_idle        (in_idle)
    );

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (clear_counters)
            stall_cnt_next = '0;
        else if (!pc_we && !in_idle && !(&stall_cnt_reg))
            stall_cnt_next = stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_cnt_reg <= '0;
        else
            stall_cnt_reg <= stall_cnt_next;
    end

    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

    localparam int CNT_W = 4;

    logic             clock;
    logic             reset_n;
    logic             id_stall, ex_stall, if_flush;
    logic             imem_req, imem_ack;
    logic [31:0]      imem_rdata, if_instr;
    logic             if_instr_valid;
    logic             me_mem_read, me_mem_write, dmem_req, dmem_ack;
    logic             pc_we, if_id_we, id_ex_we, ex_me_we, me_wb_we;
    logic             if_id_bubble, id_ex_bubble, ex_me_bubble, me_wb_bubble;
    logic             clear_counters;
    logic [CNT_W-1:0] stall_cycles;

    int n_vec  = 0;
    int n_miss = 0;

    pipeline_stall_controller #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_stall(id_stall), .ex_stall(ex_stall), .if_flush(if_flush),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_instr(if_instr), .if_instr_valid(if_instr_valid),
        .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_me_we(ex_me_we), .me_wb_we(me_wb_we),
        .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble),
        .ex_me_bubble(ex_me_bubble), .me_wb_bubble(me_wb_bubble),
        .clear_counters(clear_counters), .stall_cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the DUT in its first post-reset cycle (I_IDLE).
    task automatic apply_reset();
        reset_n = 1'b0;
        id_stall = 0; ex_stall = 0; if_flush = 0;
        imem_ack = 0; imem_rdata = 32'h0;
        me_mem_read = 0; me_mem_write = 0; dmem_ack = 0;
        clear_counters = 0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        $display("reset: idle cycle pc_we=%b imem_req=%b bubble=%b", pc_we, imem_req, if_id_bubble);
        n_vec++; if ({pc_we, imem_req, if_instr_valid} !== 3'b000) begin n_miss++; $display("FAIL reset_idle_outs: got pc_we/req/valid=%b want 000", {pc_we, imem_req, if_instr_valid}); end
        n_vec++; if ({if_id_we, if_id_bubble} !== 2'b11) begin n_miss++; $display("FAIL reset_idle_bubble: got we/bubble=%b want 11", {if_id_we, if_id_bubble}); end
        n_vec++; if (stall_cycles !== 4'd0) begin n_miss++; $display("FAIL reset_count: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_free_run();
        logic [31:0] word;
        apply_reset();
        imem_ack = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            word = 32'h2000_0010 + 32'(i * 4);
            imem_rdata = word;
            #1;
            $display("free_run[%0d]: if_instr=%h valid=%b we=%b", i, if_instr, if_instr_valid,
                     {pc_we, if_id_we, id_ex_we, ex_me_we, me_wb_we});
            n_vec++; if (if_instr !== word || if_instr_valid !== 1'b1) begin n_miss++; $display("FAIL free_run_instr: got %h/%b want %h/1", if_instr, if_instr_valid, word); end
            n_vec++; if ({pc_we, if_id_we, id_ex_we, ex_me_we, me_wb_we} !== 5'b11111 ||
                         {if_id_bubble, id_ex_bubble, ex_me_bubble, me_wb_bubble} !== 4'b0000) begin
                n_miss++; $display("FAIL free_run_ctrl: got we=%b bub=%b want 11111/0000",
                    {pc_we, if_id_we, id_ex_we, ex_me_we, me_wb_we}, {if_id_bubble, id_ex_bubble, ex_me_bubble, me_wb_bubble}); end
            tick();
        end
        n_vec++; if (stall_cycles !== 4'd0) begin n_miss++; $display("FAIL free_run_count: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_id_stall_hold();
        apply_reset();
        tick();
        id_stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
        #1;
        $display("id_stall c0: pc_we=%b if_id_we=%b id_ex_bubble=%b", pc_we, if_id_we, id_ex_bubble);
        n_vec++; if ({pc_we, if_id_we, id_ex_we, id_ex_bubble} !== 4'b0011) begin n_miss++; $display("FAIL id_stall_ctrl: got pc/ifid/idex we,bub=%b want 0011", {pc_we, if_id_we, id_ex_we, id_ex_bubble}); end
        tick();
        imem_rdata = 32'h1111_1111;
        #1;
        $display("id_stall c1: imem_req=%b if_instr=%h", imem_req, if_instr);
        n_vec++; if (imem_req !== 1'b0 || if_instr !== 32'h8C22_0004) begin n_miss++; $display("FAIL id_stall_hold: got req=%b instr=%h want 0/8c220004", imem_req, if_instr); end
        tick();
        id_stall = 1'b0;
        #1;
        $display("id_stall release: if_instr=%h valid=%b pc_we=%b count=%0d", if_instr, if_instr_valid, pc_we, stall_cycles);
        n_vec++; if (if_instr !== 32'h8C22_0004 || if_instr_valid !== 1'b1 || pc_we !== 1'b1) begin n_miss++; $display("FAIL id_release_instr: got %h/%b pc_we=%b want 8c220004/1 pc_we=1", if_instr, if_instr_valid, pc_we); end
        n_vec++; if (stall_cycles !== 4'd2) begin n_miss++; $display("FAIL id_stall_count: got %0d want 2", stall_cycles); end
        tick();
        imem_rdata = 32'h0000_5555;
        #1;
        n_vec++; if (imem_req !== 1'b1 || if_instr !== 32'h0000_5555) begin n_miss++; $display("FAIL id_after_fetch: got req=%b instr=%h want 1/00005555", imem_req, if_instr); end
    endtask

    task automatic test_mem_stall();
        apply_reset();
        tick();
        me_mem_read = 1'b1; dmem_ack = 1'b0; ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            $display("mem_stall[%0d]: me_wb_bub=%b ex_me_we=%b ex_me_bub=%b", i, me_wb_bubble, ex_me_we, ex_me_bubble);
            n_vec++; if ({dmem_req, me_wb_we, me_wb_bubble, ex_me_we, ex_me_bubble, id_ex_we, pc_we} !== 7'b1110000) begin
                n_miss++; $display("FAIL mem_stall_ctrl: got req,wbwe,wbbub,exwe,exbub,idexwe,pcwe=%b want 1110000",
                    {dmem_req, me_wb_we, me_wb_bubble, ex_me_we, ex_me_bubble, id_ex_we, pc_we}); end
            tick();
        end
        n_vec++; if (stall_cycles !== 4'd3) begin n_miss++; $display("FAIL mem_stall_count: got %0d want 3", stall_cycles); end
        me_mem_read = 1'b0; me_mem_write = 1'b1; dmem_ack = 1'b1; ex_stall = 1'b0; imem_ack = 1'b1;
        #1;
        $display("mem same-cycle ack: dmem_req=%b pc_we=%b me_wb_bub=%b", dmem_req, pc_we, me_wb_bubble);
        n_vec++; if ({dmem_req, pc_we, me_wb_bubble, ex_me_we} !== 4'b1101) begin n_miss++; $display("FAIL mem_ack_nostall: got req,pcwe,wbbub,exwe=%b want 1101", {dmem_req, pc_we, me_wb_bubble, ex_me_we}); end
    endtask

    task automatic test_flush_discard();
        apply_reset();
        tick();
        if_flush = 1'b1; imem_ack = 1'b0;
        #1;
        $display("flush: pc_we=%b if_id_we=%b bubble=%b valid=%b", pc_we, if_id_we, if_id_bubble, if_instr_valid);
        n_vec++; if ({pc_we, if_id_we, if_id_bubble, if_instr_valid} !== 4'b1110) begin n_miss++; $display("FAIL flush_ctrl: got pcwe,ifidwe,bub,valid=%b want 1110", {pc_we, if_id_we, if_id_bubble, if_instr_valid}); end
        tick();
        if_flush = 1'b0;
        #1;
        n_vec++; if ({imem_req, pc_we, if_instr_valid} !== 3'b100) begin n_miss++; $display("FAIL discard_wait: got req,pcwe,valid=%b want 100", {imem_req, pc_we, if_instr_valid}); end
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        $display("discard ack: if_instr=%h valid=%b pc_we=%b", if_instr, if_instr_valid, pc_we);
        n_vec++; if (if_instr_valid !== 1'b0 || pc_we !== 1'b0) begin n_miss++; $display("FAIL discard_drop: got valid=%b pc_we=%b want 0/0", if_instr_valid, pc_we); end
        tick();
        imem_rdata = 32'h1234_5678;
        #1;
        n_vec++; if (if_instr !== 32'h1234_5678 || if_instr_valid !== 1'b1) begin n_miss++; $display("FAIL discard_resume: got %h/%b want 12345678/1", if_instr, if_instr_valid); end
        n_vec++; if (stall_cycles !== 4'd2) begin n_miss++; $display("FAIL discard_count: got %0d want 2", stall_cycles); end
    endtask

    task automatic test_flush_during_stall();
        apply_reset();
        tick();
        if_flush = 1'b1; id_stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
        #1;
        $display("flush+id_stall: pc_we=%b if_id_bubble=%b if_id_we=%b", pc_we, if_id_bubble, if_id_we);
        n_vec++; if ({pc_we, if_id_bubble, if_id_we, id_ex_bubble} !== 4'b0001) begin n_miss++; $display("FAIL flush_ignored: got pcwe,ifidbub,ifidwe,idexbub=%b want 0001", {pc_we, if_id_bubble, if_id_we, id_ex_bubble}); end
        tick();
        id_stall = 1'b0;
        #1;
        n_vec++; if ({pc_we, if_id_bubble, if_instr_valid} !== 3'b110) begin n_miss++; $display("FAIL flush_in_hold: got pcwe,bub,valid=%b want 110", {pc_we, if_id_bubble, if_instr_valid}); end
        tick();
        if_flush = 1'b0; imem_rdata = 32'hABCD_0000;
        #1;
        n_vec++; if (if_instr !== 32'hABCD_0000 || if_instr_valid !== 1'b1) begin n_miss++; $display("FAIL flush_hold_resume: got %h/%b want abcd0000/1", if_instr, if_instr_valid); end
    endtask

    task automatic test_counter_saturate();
        apply_reset();
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        n_vec++; if (stall_cycles !== 4'd14) begin n_miss++; $display("FAIL cnt_14: got %0d want 14", stall_cycles); end
        tick();
        n_vec++; if (stall_cycles !== 4'd15) begin n_miss++; $display("FAIL cnt_15: got %0d want 15", stall_cycles); end
        tick();
        tick();
        $display("counter after saturation: %0d", stall_cycles);
        n_vec++; if (stall_cycles !== 4'd15) begin n_miss++; $display("FAIL cnt_saturate: got %0d want 15", stall_cycles); end
        clear_counters = 1'b1;
        tick();
        n_vec++; if (stall_cycles !== 4'd0) begin n_miss++; $display("FAIL cnt_clear: got %0d want 0", stall_cycles); end
        clear_counters = 1'b0;
        tick();
        $display("counter after clear + 1 stall: %0d", stall_cycles);
        n_vec++; if (stall_cycles !== 4'd1) begin n_miss++; $display("FAIL cnt_after_clear: got %0d want 1", stall_cycles); end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        tick();
        id_stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001;
        tick();
        #1;
        n_vec++; if (imem_req !== 1'b0 || if_instr_valid !== 1'b1 || stall_cycles !== 4'd1) begin n_miss++; $display("FAIL hold_before_reset: got req=%b valid=%b cnt=%0d want 0/1/1", imem_req, if_instr_valid, stall_cycles); end
        reset_n = 1'b0;
        #1;
        $display("async reset in hold: req=%b valid=%b bubble=%b cnt=%0d", imem_req, if_instr_valid, if_id_bubble, stall_cycles);
        n_vec++; if ({imem_req, if_instr_valid, pc_we} !== 3'b000 || stall_cycles !== 4'd0) begin n_miss++; $display("FAIL async_reset: got req,valid,pcwe=%b cnt=%0d want 000/0", {imem_req, if_instr_valid, pc_we}, stall_cycles); end
        id_stall = 1'b0;
        #1;
        n_vec++; if (if_id_bubble !== 1'b1) begin n_miss++; $display("FAIL async_reset_idle: got if_id_bubble=%b want 1", if_id_bubble); end
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_id_stall_hold();
        test_mem_stall();
        test_flush_discard();
        test_flush_during_stall();
        test_counter_saturate();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
